// File: rtl/joy_socd_n.sv
// Joystick SOCD cleaner: synchronizes and debounces raw directions, resolves
// opposing directions per axis according to socd_mode, and optionally limits to 4-way.
module joy_socd_n #(
    parameter int PLAYERS    = 2,
    parameter int DEB_CYCLES = 0
) (
    input  logic                   clk_sys,
    input  logic                   I_RESETn,
    input  logic [4*PLAYERS-1:0]   indir,
    input  logic [1:0]             socd_mode,
    input  logic                   fourway,
    output logic [4*PLAYERS-1:0]   outdir,
    output logic [PLAYERS-1:0]     changed
);
    localparam int NB = 4 * PLAYERS;
    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES > 0 ? DEB_CYCLES - 1 : 0);

    logic [NB-1:0] s1_q, s2_q, deb_q, deb_d, deb_prev_q;

    always_ff @(posedge clk_sys) begin
        if (!I_RESETn) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
        end else begin
            s1_q       <= indir;
            s2_q       <= s1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
        end
    end

    generate
        if (DEB_CYCLES == 0) begin : g_nodeb
            always_comb deb_d = s2_q;
        end else begin : g_deb
            logic [NB-1:0]       s2_prev_q;
            logic [NB-1:0][15:0] cnt_q, cnt_d;

            // A bit must sit stable and different from deb for DEB_CYCLES cycles to be accepted.
            always_comb begin
                deb_d = deb_q;
                cnt_d = cnt_q;
                for (int i = 0; i < NB; i++) begin
                    if (s2_q[i] == deb_q[i] || s2_q[i] != s2_prev_q[i]) begin
                        cnt_d[i] = '0;
                    end else if (cnt_q[i] == DEB_LAST) begin
                        deb_d[i] = s2_q[i];
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 16'd1;
                    end
                end
            end

            always_ff @(posedge clk_sys) begin
                if (!I_RESETn) begin
                    s2_prev_q <= '0;
                    cnt_q     <= '0;
                end else begin
                    s2_prev_q <= s2_q;
                    cnt_q     <= cnt_d;
                end
            end
        end
    endgenerate

    // Pair layout per axis: bit0 = R/D, bit1 = L/U; records use the same encoding.
    function automatic logic [1:0] next_rec(input logic [1:0] rec, input logic [1:0] cur,
                                            input logic [1:0] prev, input logic [1:0] mode);
        logic [1:0] rise, pick;
        rise     = cur & ~prev;
        pick     = (rise == 2'b11) ? 2'b10 : rise;
        next_rec = rec;
        if (cur == 2'b00)
            next_rec = 2'b00;
        else if (mode == 2'd2) begin
            if (prev == 2'b00) next_rec = pick;
        end else if (rise != 2'b00)
            next_rec = pick;
    endfunction

    function automatic logic [1:0] resolve(input logic [1:0] cur, input logic [1:0] rec,
                                           input logic [1:0] mode);
        if (cur != 2'b11)
            resolve = cur;
        else begin
            case (mode)
                2'd1:    resolve = 2'b00;
                2'd3:    resolve = 2'b11;
                default: resolve = rec;
            endcase
        end
    endfunction

    logic [PLAYERS-1:0][1:0][1:0] rec_q, rec_d, res_c;
    logic [PLAYERS-1:0][1:0]      nz_q, nz_d;
    logic [PLAYERS-1:0]           vaxis_q, vaxis_d;
    logic [NB-1:0]                outdir_q, outdir_d;
    logic [PLAYERS-1:0]           changed_q, changed_d;

    always_comb begin
        rec_d     = rec_q;
        nz_d      = nz_q;
        vaxis_d   = vaxis_q;
        res_c     = '0;
        outdir_d  = '0;
        changed_d = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            for (int a = 0; a < 2; a++) begin
                rec_d[p][a] = next_rec(rec_q[p][a], deb_q[4*p+2*a +: 2],
                                       deb_prev_q[4*p+2*a +: 2], socd_mode);
                res_c[p][a] = resolve(deb_q[4*p+2*a +: 2], rec_d[p][a], socd_mode);
                nz_d[p][a]  = |res_c[p][a];
            end
            // Tracker follows the axis that most recently became active; vertical wins ties.
            if (nz_d[p][1] && !nz_q[p][1])
                vaxis_d[p] = 1'b1;
            else if (nz_d[p][0] && !nz_q[p][0])
                vaxis_d[p] = 1'b0;
            outdir_d[4*p +: 4] = {res_c[p][1], res_c[p][0]};
            if (fourway && nz_d[p][0] && nz_d[p][1])
                outdir_d[4*p +: 4] = vaxis_d[p] ? {res_c[p][1], 2'b00} : {2'b00, res_c[p][0]};
            changed_d[p] = outdir_d[4*p +: 4] != outdir_q[4*p +: 4];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!I_RESETn) begin
            rec_q     <= '0;
            nz_q      <= '0;
            vaxis_q   <= '0;
            outdir_q  <= '0;
            changed_q <= '0;
        end else begin
            rec_q     <= rec_d;
            nz_q      <= nz_d;
            vaxis_q   <= vaxis_d;
            outdir_q  <= outdir_d;
            changed_q <= changed_d;
        end
    end

    assign outdir  = outdir_q;
    assign changed = changed_q;
endmodule

// File: tb/tb_joy_socd_n.sv
// Bench for joy_socd_n: 4-player no-debounce DUT against a timestamp-based model,
// plus a 1-player DEB_CYCLES=8 DUT for debounce timing.
module tb_joy_socd_n;
    logic        clk_sys = 1'b0;
    logic        I_RESETn = 1'b0;
    logic [15:0] indir = '0;
    logic [1:0]  socd_mode = 2'd0;
    logic        fourway = 1'b0;
    logic [15:0] outdir;
    logic [3:0]  changed;
    logic [3:0]  indir_b = '0;
    logic [3:0]  outdir_b;
    logic [0:0]  changed_b;

    int checks = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    joy_socd_n #(.PLAYERS(4), .DEB_CYCLES(0)) u_dut (
        .clk_sys(clk_sys), .I_RESETn(I_RESETn), .indir(indir), .socd_mode(socd_mode),
        .fourway(fourway), .outdir(outdir), .changed(changed)
    );

    joy_socd_n #(.PLAYERS(1), .DEB_CYCLES(8)) u_deb (
        .clk_sys(clk_sys), .I_RESETn(I_RESETn), .indir(indir_b), .socd_mode(socd_mode),
        .fourway(fourway), .outdir(outdir_b), .changed(changed_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: the debounced vector is the input three edges back; opposing
    // pairs are resolved from press timestamps and the direction that opened the hold.
    logic [15:0] hist[$];
    logic [15:0] prev_deb, exp_out;
    logic [3:0]  exp_chg;
    int          t;
    int          press_t[16];
    int          gain_t[4][2];
    logic        pnz[4][2];
    logic [1:0]  first_r[4][2];

    task automatic model_reset();
        hist = {16'h0, 16'h0, 16'h0};
        prev_deb = '0; exp_out = '0; exp_chg = '0; t = 0;
        for (int b = 0; b < 16; b++) press_t[b] = 0;
        for (int p = 0; p < 4; p++)
            for (int a = 0; a < 2; a++) begin
                gain_t[p][a] = 0; pnz[p][a] = 1'b0; first_r[p][a] = 2'b00;
            end
    endtask

    task automatic model_feed(input logic [15:0] d);
        logic [1:0]  cur, prv;
        logic [1:0]  res[2];
        logic [15:0] o;
        t++;
        o = '0;
        for (int b = 0; b < 16; b++) if (d[b] && !prev_deb[b]) press_t[b] = t;
        for (int p = 0; p < 4; p++) begin
            for (int a = 0; a < 2; a++) begin
                cur = d[4*p+2*a +: 2];
                prv = prev_deb[4*p+2*a +: 2];
                if (prv == 2'b00 && cur != 2'b00) first_r[p][a] = (cur == 2'b11) ? 2'b10 : cur;
                if (cur != 2'b11) res[a] = cur;
                else case (socd_mode)
                    2'd1: res[a] = 2'b00;
                    2'd3: res[a] = 2'b11;
                    2'd2: res[a] = first_r[p][a];
                    default: res[a] = (press_t[4*p+2*a+1] >= press_t[4*p+2*a]) ? 2'b10 : 2'b01;
                endcase
                if (res[a] != 2'b00 && !pnz[p][a]) gain_t[p][a] = t;
                pnz[p][a] = (res[a] != 2'b00);
            end
            if (fourway && res[0] != 2'b00 && res[1] != 2'b00) begin
                if (gain_t[p][1] >= gain_t[p][0]) res[0] = 2'b00;
                else res[1] = 2'b00;
            end
            o[4*p +: 4] = {res[1], res[0]};
        end
        for (int p = 0; p < 4; p++) exp_chg[p] = (o[4*p +: 4] != exp_out[4*p +: 4]);
        exp_out = o;
        prev_deb = d;
    endtask

    task automatic step(input logic [15:0] v);
        indir = v;
        @(posedge clk_sys); #1;
        hist.push_back(v);
        model_feed(hist[hist.size()-4]);
        if (hist.size() > 4) void'(hist.pop_front());
        chk("model_outdir", outdir, exp_out);
        chk("model_changed", changed, exp_chg);
    endtask

    task automatic steps(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic do_reset();
        I_RESETn = 1'b0;
        @(posedge clk_sys); #1;
        chk("rst_outdir", outdir, 0);
        chk("rst_changed", changed, 0);
        chk("rst_outdir_b", outdir_b, 0);
        chk("rst_changed_b", changed_b, 0);
        I_RESETn = 1'b1;
        model_reset();
    endtask

    int          pulses;
    logic [15:0] v;

    initial begin
        model_reset();
        @(posedge clk_sys); #1;
        do_reset();

        // last-wins: R then L added; L released
        socd_mode = 2'd0; fourway = 1'b0;
        steps(16'h0001, 10);
        steps(16'h0003, 4);  chk("lw_add_L", outdir[1:0], 2'b10);
        steps(16'h0001, 3);  chk("lw_rel_L_edge3", outdir[1:0], 2'b10);
        steps(16'h0001, 1);  chk("lw_rel_L_edge4", outdir[1:0], 2'b01);
        steps(16'h0000, 6);

        // simultaneous U+D under modes 0, 1, 3
        steps(16'h000C, 4);  chk("ud_mode0", outdir[3:2], 2'b10);
        steps(16'h0000, 6);
        socd_mode = 2'd1;
        steps(16'h000C, 4);  chk("ud_mode1", outdir[3:2], 2'b00);
        steps(16'h0000, 6);
        socd_mode = 2'd3;
        steps(16'h000C, 4);  chk("ud_mode3", outdir[3:2], 2'b11);
        steps(16'h0000, 6);

        // first-wins: D then U added; D released
        socd_mode = 2'd2;
        steps(16'h0004, 6);
        steps(16'h000C, 5);  chk("fw_hold_D", outdir[3:2], 2'b01);
        steps(16'h0008, 5);  chk("fw_rel_D", outdir[3:2], 2'b10);
        steps(16'h0000, 6);

        // 4-way restriction
        socd_mode = 2'd0; fourway = 1'b1;
        steps(16'h0008, 6);
        steps(16'h0009, 5);  chk("4w_add_R", outdir[3:0], 4'b0001);
        steps(16'h0008, 5);  chk("4w_rel_R", outdir[3:0], 4'b1000);
        steps(16'h0000, 6);
        steps(16'h0009, 5);  chk("4w_UR_together", outdir[3:0], 4'b1000);
        steps(16'h0000, 6);
        fourway = 1'b0;

        // debounce DUT: 5-cycle glitch ignored, long hold accepted at edge 12
        for (int k = 1; k <= 25; k++) begin
            indir_b = (k <= 5) ? 4'b0001 : 4'b0000;
            step(16'h0000);
            chk("deb_glitch", outdir_b, 4'b0000);
        end
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            indir_b = 4'b0001;
            step(16'h0000);
            chk("deb_hold_edge", outdir_b[0], (k >= 12) ? 1 : 0);
            if (changed_b[0]) pulses++;
        end
        chk("deb_changed_once", pulses, 1);
        indir_b = 4'b0000;
        steps(16'h0000, 15);

        // reset while everything is held, then every player recovers to U+L
        steps(16'hFFFF, 6);
        do_reset();
        steps(16'hFFFF, 3);  chk("rst_recover_edge3", outdir, 16'h0000);
        steps(16'hFFFF, 1);  chk("rst_recover_UL", outdir, 16'hAAAA);
        steps(16'h0000, 6);

        // randomized segments; inputs drained before each mode change
        for (int seg = 0; seg < 8; seg++) begin
            socd_mode = 2'($urandom_range(0, 3));
            fourway   = 1'($urandom_range(0, 1));
            v = '0;
            for (int i = 0; i < 150; i++) begin
                for (int b = 0; b < 16; b++) if ($urandom_range(0, 5) == 0) v[b] = ~v[b];
                if ($urandom_range(0, 15) == 0) fourway = ~fourway;
                step(v);
            end
            steps(16'h0000, 6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/joy_socd_n.md
JOY_SOCD_N -- requirements
Module: joy_socd_n

Interface
REQ-001 SHALL have parameter PLAYERS, default 2, which sets the number of independent joystick channels (1..4).
REQ-002 SHALL have parameter DEB_CYCLES, default 0, which sets the debounce hold length in clk_sys cycles (0 = debounce bypassed, max 65535).
REQ-003 SHALL have port clk_sys, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port I_RESETn, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port indir, input, 4*PLAYERS bits: raw directions, active-high, asynchronous to clk_sys; player p occupies [4p+3:4p] as U,D,L,R (bit 0 = R).
REQ-006 SHALL have port socd_mode, input, 2 bits: 0 last-wins, 1 neutral, 2 first-wins, 3 pass-through; shared by all players.
REQ-007 SHALL have port fourway, input, 1 bit: 1 restricts every player's output to at most one axis.
REQ-008 SHALL have port outdir, output, 4*PLAYERS bits: resolved directions, with the same layout as indir, registered.
REQ-009 SHALL have port changed, output, PLAYERS bits: a one-cycle pulse when that player's outdir differs from its previous value.

Function
REQ-010 SHALL pass each indir bit through a 2-flop synchronizer (s1, s2) before any other use.
REQ-011 SHALL, with DEB_CYCLES=0, take the debounced value deb equal to s2 delayed by one register.
REQ-012 SHALL, with DEB_CYCLES>0, keep a per-bit counter that clears whenever s2==deb or s2 toggled in the previous cycle, increments otherwise, and loads deb<=s2 and clears when the counter reaches DEB_CYCLES-1.
REQ-013 SHALL, for a glitch shorter than DEB_CYCLES cycles after synchronization, leave deb unchanged.
REQ-014 SHALL detect per-bit rise as deb & ~deb_prev, where deb_prev is deb registered once.
REQ-015 SHALL hold, per player per axis, a 2-bit record last_h (01=R, 10=L, 00=none) and last_v (01=D, 10=U, 00=none).
REQ-016 SHALL update last_h/last_v in last-wins mode on every rise; a simultaneous rise of both opposite bits SHALL record L (horizontal) and U (vertical).
REQ-017 SHALL update the records in first-wins mode only when the axis previously had neither bit held; a simultaneous rise of both SHALL record L and U.
REQ-018 SHALL clear an axis record to 00 when both bits of that axis are released, in any mode.
REQ-019 SHALL resolve each axis, when both bits are held: last-wins and first-wins output the record (00 if the record is 00); neutral outputs 00; pass-through outputs 11.
REQ-020 SHALL output the deb pair unchanged when the two bits of an axis are not both held.
REQ-021 SHALL track, when fourway=1, which axis most recently gained a nonzero resolved value (vertical wins on a simultaneous gain).
REQ-022 SHALL, when fourway=1 and both axes are nonzero, output only the tracked axis and zero the other.
REQ-023 SHALL, when fourway=1 and only one axis is nonzero, output that axis.
REQ-024 SHALL register the resolver and 4-way stage into outdir, so that latency from an indir change to outdir is 4 clk_sys edges with DEB_CYCLES=0 and 4+DEB_CYCLES edges otherwise.
REQ-025 SHALL apply changes of socd_mode or fourway from the next clock edge, with records retained and not cleared.
REQ-026 SHALL keep players fully independent, with no cross-player interaction.

Reset
REQ-027 SHALL, while I_RESETn=0 at a clock edge, clear s1, s2, deb, deb_prev, counters, records, axis trackers, outdir and changed to 0.
REQ-028 SHALL treat bits held through reset release as fresh rises, in lane order, once they reach deb.
REQ-029 SHALL, on a reset asserted mid-debounce or mid-hold, discard all partial state with no output glitch beyond outdir=0.

Verification
REQ-030 SHALL cover: DEB=0, mode 0, R held, then L added 10 cycles later -> outdir[1:0]=10; release L -> 01 four edges later.
REQ-031 SHALL cover: mode 0, U and D rising in the same cycle -> outdir[3:2]=10; mode 1, same stimulus -> 00; mode 3 -> 11.
REQ-032 SHALL cover: mode 2, D held, then U added -> outdir[3:2]=01 held; release D -> 10.
REQ-033 SHALL cover: DEB_CYCLES=8, R pulse of 5 cycles -> outdir unchanged; R held 20 cycles -> outdir[0]=1 at edge 12 and changed pulses once.
REQ-034 SHALL cover: fourway=1, U held, then R added -> outdir=0001; release R -> 1000; U and R rising together -> 1000.
REQ-035 SHALL cover: PLAYERS=4, I_RESETn low for 1 cycle while all inputs are held -> all outputs 0 at that edge; each player independently resolves to U/L after recovery.
